// File: rtl/apb_pkg.sv
`timescale 1ns/1ps
// apb_pkg: shared types and constants for the APB requester and its benches.
package apb_pkg;

    // Byte strobes carried on both the CPU port and the APB bus.
    localparam int STRB_WIDTH = 4;

    // Transfer phases of the requester.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Interrupt controller register map on the peripheral bus.
    localparam logic [31:0] INTCTRL_PENDING = 32'h2000_0000;
    localparam logic [31:0] INTCTRL_MASK    = 32'h2000_0004;

endpackage

// File: rtl/apb_watchdog.sv
`timescale 1ns/1ps
// apb_watchdog: counts stalled ACCESS cycles and flags when the limit is hit.
// Only instantiated when APB_REQUESTER_TIMEOUT_EN is defined.
module apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic pclk,
    input  logic presetn,
    input  logic in_access,
    input  logic pready,
    output logic expired
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_r;
    logic                 at_limit_s;

    assign at_limit_s = (count_r == CNT_LIMIT);
    // The requester gives pready priority, so expiry only reflects the count.
    assign expired    = in_access && at_limit_s;

    // Count stalled ACCESS cycles; outside ACCESS the count sits at zero so
    // every transfer enters ACCESS with a fresh count.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (!in_access) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (!pready && !at_limit_s) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/apb_requester.sv
`timescale 1ns/1ps
// apb_requester: turns one CPU valid/ready load/store request into an APB
// SETUP -> ACCESS transfer and returns read data / error as a one-cycle pulse.
// Optional ACCESS-phase timeout: define APB_REQUESTER_TIMEOUT_EN.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstb,
    input  logic                  req_write,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [STRB_WIDTH-1:0] pstb,
    input  logic                  pready,
    input  logic                  perr,
    output logic                  bus_err
);

    apb_state_t            state_r,     state_nxt_s;
    logic                  req_ready_r, req_ready_nxt_s;
    logic                  rsp_valid_r, rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
    logic                  rsp_err_r,   rsp_err_nxt_s;
    logic [ADDR_WIDTH-1:0] paddr_r,     paddr_nxt_s;
    logic [DATA_WIDTH-1:0] pdata_r,     pdata_nxt_s;
    logic                  psel_r,      psel_nxt_s;
    logic                  penable_r,   penable_nxt_s;
    logic                  pwrite_r,    pwrite_nxt_s;
    logic [STRB_WIDTH-1:0] pstb_r,      pstb_nxt_s;
    logic                  bus_err_r,   bus_err_nxt_s;
    logic                  wd_expired_s;

`ifdef APB_REQUESTER_TIMEOUT_EN
    logic in_access_s;
    assign in_access_s = (state_r == ACCESS);

    apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .pclk      (pclk),
        .presetn   (presetn),
        .in_access (in_access_s),
        .pready    (pready),
        .expired   (wd_expired_s)
    );
`else
    // Without the watchdog an ACCESS phase only ends on pready.
    assign wd_expired_s = 1'b0;
`endif

    // Next state and next value of every registered output.
    always_comb begin
        state_nxt_s     = state_r;
        paddr_nxt_s     = paddr_r;
        pdata_nxt_s     = pdata_r;
        pwrite_nxt_s    = pwrite_r;
        pstb_nxt_s      = pstb_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        psel_nxt_s      = 1'b0;
        penable_nxt_s   = 1'b0;
        rsp_valid_nxt_s = 1'b0;
        rsp_err_nxt_s   = 1'b0;
        bus_err_nxt_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    paddr_nxt_s  = req_addr;
                    pdata_nxt_s  = req_wdata;
                    pwrite_nxt_s = req_write;
                    // Reads never carry strobes onto the bus.
                    pstb_nxt_s   = req_write ? req_wstb : {STRB_WIDTH{1'b0}};
                    psel_nxt_s   = 1'b1;
                    state_nxt_s  = SETUP;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            SETUP: begin
                psel_nxt_s    = 1'b1;
                penable_nxt_s = 1'b1;
                state_nxt_s   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = perr;
                    bus_err_nxt_s   = perr;
                    if (!pwrite_r) begin
                        rsp_rdata_nxt_s = prdata;
                    end else begin
                        rsp_rdata_nxt_s = rsp_rdata_r;
                    end
                    state_nxt_s = IDLE;
                end else if (wd_expired_s) begin
                    // Silent completer: terminate as an erroring completion.
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b1;
                    bus_err_nxt_s   = 1'b1;
                    state_nxt_s     = IDLE;
                end else begin
                    psel_nxt_s    = 1'b1;
                    penable_nxt_s = 1'b1;
                    state_nxt_s   = ACCESS;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        req_ready_nxt_s = (state_nxt_s == IDLE);
    end

    // State and output registers; reset clears psel/penable immediately.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            paddr_r     <= {ADDR_WIDTH{1'b0}};
            pdata_r     <= {DATA_WIDTH{1'b0}};
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            pstb_r      <= {STRB_WIDTH{1'b0}};
            bus_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= req_ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            paddr_r     <= paddr_nxt_s;
            pdata_r     <= pdata_nxt_s;
            psel_r      <= psel_nxt_s;
            penable_r   <= penable_nxt_s;
            pwrite_r    <= pwrite_nxt_s;
            pstb_r      <= pstb_nxt_s;
            bus_err_r   <= bus_err_nxt_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign paddr     = paddr_r;
    assign pdata     = pdata_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign pstb      = pstb_r;
    assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_apb_requester.sv
`timescale 1ns/1ps
// tb_apb_requester: scoreboard bench for apb_requester with a configurable
// APB completer model. Timeout scenario runs when APB_REQUESTER_TIMEOUT_EN is set.
module tb_apb_requester;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstb;
    logic        rsp_valid, rsp_err, bus_err;
    logic [31:0] rsp_rdata, paddr, pdata, prdata;
    logic        psel, penable, pwrite, pready, perr;
    logic [3:0]  pstb;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    rsp_t        sb[$];
    logic [31:0] exp_last;   // rsp_rdata the bench believes is held

    // Completer model: pready after wait_n stalled ACCESS cycles; read data
    // is rd_key ^ paddr so every address returns a distinct word.
    int          wait_n = 0;
    int          acc_cnt;
    logic        stall_forever = 1'b0;
    logic        junk = 1'b0;
    logic        slv_err = 1'b0;
    logic [31:0] rd_key = 32'h0;

    bit tl_sel [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit tl_en  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit tl_rsp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 pclk = ~pclk;

    apb_requester #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstb  (req_wstb),
        .req_write (req_write),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pdata     (pdata),
        .prdata    (prdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pstb      (pstb),
        .pready    (pready),
        .perr      (perr),
        .bus_err   (bus_err)
    );

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) acc_cnt <= 0;
        else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign pready = junk || (psel && penable && !stall_forever && (acc_cnt >= wait_n));
    assign perr   = junk || (psel && penable && slv_err);
    assign prdata = rd_key ^ paddr;

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge pclk) begin
        rsp_t e;
        if (presetn === 1'b1 && (rsp_valid === 1'b1 || bus_err === 1'b1)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b bus_err=%b with nothing outstanding", rsp_valid, bus_err);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== 1'b1 || rsp_err !== e.err || bus_err !== e.err || rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rsp: got valid=%b err=%b bus_err=%b rdata=%h expected valid=1 err=%b bus_err=%b rdata=%h",
                             rsp_valid, rsp_err, bus_err, rsp_rdata, e.err, e.err, e.rdata);
                end
            end
        end
    end

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        req_addr = a; req_wdata = d; req_wstb = s; req_write = w; req_valid = 1'b1;
        @(negedge pclk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge pclk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_apb_ctl: got %b expected 000", {psel, penable, pwrite}); end
        checks++; if ({rsp_valid, rsp_err, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_rsp: got %b expected 000", {rsp_valid, rsp_err, bus_err}); end
        checks++; if (paddr !== 32'h0 || pdata !== 32'h0 || pstb !== 4'h0) begin errors++; $display("FAIL reset_apb_data: got %h %h %h expected zeros", paddr, pdata, pstb); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        presetn = 1'b1;
        exp_last = 32'h0;
        @(negedge pclk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_read();
        wait_n = 1; rd_key = 32'h2000_0002;   // INTCTRL_PENDING returns 0x2
        sb.push_back('{rdata: 32'h0000_0002, err: 1'b0});
        exp_last = 32'h0000_0002;
        drive_req(INTCTRL_PENDING, 32'hDEAD_BEEF, 4'hF, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge pclk);
            checks++;
            if (psel !== tl_sel[k-1] || penable !== tl_en[k-1] || rsp_valid !== tl_rsp[k-1]) begin
                errors++;
                $display("FAIL read_timeline c%0d: got sel/en/rsp=%b%b%b expected %b%b%b", k, psel, penable, rsp_valid, tl_sel[k-1], tl_en[k-1], tl_rsp[k-1]);
            end
            if (k <= 3) begin
                checks++;
                if (pstb !== 4'h0 || pwrite !== 1'b0 || paddr !== INTCTRL_PENDING) begin
                    errors++;
                    $display("FAIL read_bus c%0d: got stb=%h wr=%b addr=%h expected 0 0 %h", k, pstb, pwrite, paddr, INTCTRL_PENDING);
                end
            end
            if (k == 4) begin
                checks++; if (rsp_rdata !== 32'h2) begin errors++; $display("FAIL read_rdata: got %h expected 00000002", rsp_rdata); end
            end
        end
    endtask

    task automatic test_write();
        wait_n = 1;
        sb.push_back('{rdata: exp_last, err: 1'b0});
        drive_req(INTCTRL_MASK, 32'h0000_0003, 4'hF, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge pclk);
            checks++;
            if (psel !== tl_sel[k-1] || penable !== tl_en[k-1] || rsp_valid !== tl_rsp[k-1]) begin
                errors++;
                $display("FAIL write_timeline c%0d: got sel/en/rsp=%b%b%b expected %b%b%b", k, psel, penable, rsp_valid, tl_sel[k-1], tl_en[k-1], tl_rsp[k-1]);
            end
            if (k <= 3) begin
                checks++;
                if (paddr !== INTCTRL_MASK || pdata !== 32'h3 || pwrite !== 1'b1 || pstb !== 4'hF) begin
                    errors++;
                    $display("FAIL write_bus c%0d: got %h %h %b %h expected %h 00000003 1 f", k, paddr, pdata, pwrite, pstb, INTCTRL_MASK);
                end
            end
            if (k == 4) begin
                checks++; if (rsp_err !== 1'b0 || rsp_rdata !== exp_last) begin errors++; $display("FAIL write_rsp: got err=%b rdata=%h expected 0 %h", rsp_err, rsp_rdata, exp_last); end
            end
        end
    endtask

    task automatic test_stall_error();
        int n_sel = 0, n_en = 0;
        bit got = 0;
        wait_n = 5; slv_err = 1'b1;
        sb.push_back('{rdata: exp_last, err: 1'b1});
        drive_req(32'h2000_0008, 32'h0000_00AA, 4'h3, 1'b1);
        for (int c = 0; c < 30 && !got; c++) begin
            if (c > 0) @(negedge pclk);
            if (psel === 1'b1) n_sel++;
            if (penable === 1'b1) n_en++;
            if (rsp_valid === 1'b1) begin
                got = 1;
                checks++; if (rsp_err !== 1'b1 || bus_err !== 1'b1) begin errors++; $display("FAIL stall_err_flags: got err=%b bus_err=%b expected 1 1", rsp_err, bus_err); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL stall_rsp_timeout: got no response expected one within 30 cycles"); end
        checks++; if (n_en != 6) begin errors++; $display("FAIL stall_penable_cycles: got %0d expected 6", n_en); end
        checks++; if (n_sel != 7) begin errors++; $display("FAIL stall_psel_cycles: got %0d expected 7", n_sel); end
        @(negedge pclk);
        checks++; if (bus_err !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse_width: got bus_err=%b rsp_valid=%b expected 0 0", bus_err, rsp_valid); end
        slv_err = 1'b0;
    endtask

    task automatic test_idle_ignore();
        junk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            checks++;
            if (rsp_valid !== 1'b0 || bus_err !== 1'b0 || psel !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_ignore c%0d: got rsp=%b berr=%b psel=%b ready=%b expected 0 0 0 1", k, rsp_valid, bus_err, psel, req_ready);
            end
        end
        junk = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        bit accepted, setup_due = 0;
        logic [31:0] a;
        wait_n = 0; rd_key = 32'hC0DE_0000;
        req_addr = INTCTRL_PENDING; req_wdata = 32'h0000_1000; req_wstb = 4'hF; req_write = 1'b1; req_valid = 1'b1;
        for (int c = 0; c < 80 && (sent < 6 || sb.size() != 0); c++) begin
            if (setup_due) begin
                setup_due = 0;
                checks++; if (psel !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL b2b_setup: got sel/en=%b%b expected 10", psel, penable); end
            end
            accepted = (req_valid === 1'b1 && req_ready === 1'b1);
            if (accepted) begin
                if (sent > 0) begin
                    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_accept_on_rsp: got rsp_valid=%b expected 1", rsp_valid); end
                end
                if (req_write) begin
                    sb.push_back('{rdata: exp_last, err: 1'b0});
                end else begin
                    exp_last = rd_key ^ req_addr;
                    sb.push_back('{rdata: exp_last, err: 1'b0});
                end
                sent++;
            end
            @(negedge pclk);
            if (accepted) begin
                setup_due = 1;
                if (sent < 6) begin
                    a = INTCTRL_PENDING + 32'(4 * sent);
                    req_addr = a; req_wdata = 32'h0000_1000 + 32'(sent); req_write = (sent % 2 == 0);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        @(negedge pclk);
        checks++; if (sent != 6) begin errors++; $display("FAIL b2b_sent: got %0d expected 6", sent); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drained: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        stall_forever = 1'b1; rd_key = 32'h0BAD_0000;
        drive_req(INTCTRL_MASK, 32'h0, 4'h0, 1'b0);
        @(negedge pclk);
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL mid_in_access: got penable=%b expected 1", penable); end
        #2 presetn = 1'b0;
        #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got sel/en/ready=%b%b%b expected 000", psel, penable, req_ready); end
        stall_forever = 1'b0;
        exp_last = 32'h0;
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_recover: got ready=%b rsp=%b expected 1 0", req_ready, rsp_valid); end
        rd_key = 32'h1234_0000;
        exp_last = rd_key ^ INTCTRL_PENDING;
        sb.push_back('{rdata: exp_last, err: 1'b0});
        drive_req(INTCTRL_PENDING, 32'h0, 4'hF, 1'b0);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge pclk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL mid_fresh_read: got %0d outstanding expected 0", sb.size()); end
        checks++; if (rsp_rdata !== exp_last) begin errors++; $display("FAIL mid_fresh_rdata: got %h expected %h", rsp_rdata, exp_last); end
    endtask

`ifdef APB_REQUESTER_TIMEOUT_EN
    task automatic test_timeout();
        int n_en = 0;
        bit got = 0;
        stall_forever = 1'b1;
        sb.push_back('{rdata: exp_last, err: 1'b1});
        drive_req(INTCTRL_MASK, 32'h5, 4'h1, 1'b1);
        for (int c = 0; c < 30 && !got; c++) begin
            if (c > 0) @(negedge pclk);
            if (penable === 1'b1) n_en++;
            if (rsp_valid === 1'b1) begin
                got = 1;
                checks++;
                if (rsp_err !== 1'b1 || bus_err !== 1'b1 || psel !== 1'b0 || req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_flags: got err=%b berr=%b psel=%b ready=%b expected 1 1 0 1", rsp_err, bus_err, psel, req_ready);
                end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL timeout_rsp: got no response expected one within 30 cycles"); end
        checks++; if (n_en != 9) begin errors++; $display("FAIL timeout_access_cycles: got %0d expected 9", n_en); end
        stall_forever = 1'b0;
        @(negedge pclk);
    endtask
`endif

    initial begin
        presetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstb = 4'h0;
        test_reset();
        test_read();
        test_write();
        test_stall_error();
        test_idle_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_REQUESTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule
